booth_r4_macc_ctrl: RTL and testbench

//  Sequencer for the radix-4 Booth MACC datapath. Takes one signed operand pair per handshake.

---
 rtl/macc_pkg.sv | 40 ++++
 rtl/booth_r4_pp_sel.sv | 40 ++++
 rtl/booth_r4_macc_ctrl.sv | 117 +++++++++++
 tb/tb_booth_r4_macc_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/macc_pkg.sv
// Shared definitions for the radix-4 Booth MACC sequencer: FSM states,
// Booth digit codes and the digit-count helper.
package macc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } digit_t;

    localparam int W_DEFAULT = 8;
    localparam int NDIG      = W_DEFAULT / 2;

    function automatic int ndig(input int w);
        return w / 2;
    endfunction

    // Radix-4 Booth recoding of the triplet {b[2i+1], b[2i], b[2i-1]}.
    function automatic digit_t booth_digit(input logic [2:0] bits);
        digit_t d;
        case (bits)
            3'b001, 3'b010: d = P1;
            3'b011:         d = P2;
            3'b100:         d = M2;
            3'b101, 3'b110: d = M1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_pp_sel.sv
// Booth partial-product selector: magnitude (A or 2A, sign-extended to 2W),
// negate flag for the adder carry-in, and a zero flag.
module booth_r4_pp_sel
    import macc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]     bits,
    input  logic [W-1:0]   a,
    output logic [2*W-1:0] mag,
    output logic           neg,
    output logic           zero
);

    logic [2*W-1:0] a_ext;
    digit_t         digit;

    assign a_ext = (2*W)'($signed(a));
    assign digit = booth_digit(bits);

    always_comb begin
        mag  = '0;
        neg  = 1'b0;
        zero = 1'b0;
        case (digit)
            P1: mag = a_ext;
            P2: mag = a_ext << 1;
            M1: begin
                mag = a_ext;
                neg = 1'b1;
            end
            M2: begin
                mag = a_ext << 1;
                neg = 1'b1;
            end
            default: zero = 1'b1;
        endcase
    end

endmodule

// File: rtl/booth_r4_macc_ctrl.sv
// Radix-4 Booth multiply-accumulate sequencer: one digit per cycle into a
// 2W product, then a wrapping signed accumulate with sticky overflow.
module booth_r4_macc_ctrl
    import macc_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             acc_ovf,
    output logic             busy
);

    localparam int ND    = ndig(W);
    localparam int CNT_W = (ND > 1) ? $clog2(ND) : 1;

    state_t             state_reg, state_next;
    logic [W-1:0]       a_reg, b_reg;
    logic               clr_reg;
    logic [2*W-1:0]     prod_reg, prod_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic               ovf_reg, ovf_next;

    logic [W:0]         b_ext, b_shifted;
    logic [2*W-1:0]     pp_mag, pp_term, pp_addend;
    logic               pp_neg, pp_zero;
    logic [ACC_W-1:0]   acc_base, prod_ext, acc_sum;
    logic               last_digit;

    // b[-1] is the implicit zero below the LSB; each digit advances two bits.
    assign b_ext     = {b_reg, 1'b0};
    assign b_shifted = b_ext >> {cnt_reg, 1'b0};

    booth_r4_pp_sel #(.W(W)) u_pp_sel (
        .bits (b_shifted[2:0]),
        .a    (a_reg),
        .mag  (pp_mag),
        .neg  (pp_neg),
        .zero (pp_zero)
    );

    assign pp_term    = (pp_mag ^ {(2*W){pp_neg}}) + {{(2*W-1){1'b0}}, pp_neg};
    assign pp_addend  = pp_zero ? '0 : (pp_term << {cnt_reg, 1'b0});
    assign last_digit = (cnt_reg == CNT_W'(ND - 1));

    assign acc_base = clr_reg ? '0 : acc_reg;
    assign prod_ext = ACC_W'($signed(prod_reg));
    assign acc_sum  = acc_base + prod_ext;

    always_comb begin
        state_next = state_reg;
        prod_next  = prod_reg;
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = ITER;
            ITER: begin
                prod_next = prod_reg + pp_addend;
                if (last_digit) state_next = ACC;
            end
            ACC: begin
                acc_next   = acc_sum;
                // Signed overflow: operands agree in sign, result does not.
                ovf_next   = ovf_reg |
                             ((acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                              (acc_sum[ACC_W-1] != acc_base[ACC_W-1]));
                state_next = DONE;
            end
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            clr_reg   <= 1'b0;
            prod_reg  <= '0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
            if (state_reg == IDLE && in_valid) begin
                a_reg    <= in_a;
                b_reg    <= in_b;
                clr_reg  <= in_clr;
                prod_reg <= '0;
                cnt_reg  <= '0;
            end else begin
                prod_reg <= prod_next;
                if (state_reg == ITER) cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out_acc   = acc_reg;
    assign acc_ovf   = ovf_reg;

endmodule

// File: tb/tb_booth_r4_macc_ctrl.sv
// Self-checking bench for booth_r4_macc_ctrl (W=8, ACC_W=20) against an
// arithmetic reference model of the multiply-accumulate.
module tb_booth_r4_macc_ctrl;

    localparam int W     = 8;
    localparam int ACC_W = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic             in_clr = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_acc;
    logic             acc_ovf;
    logic             busy;

    int tests = 0;
    int fails = 0;

    longint model_acc = 0;
    bit     model_ovf = 1'b0;

    booth_r4_macc_ctrl #(.W(W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_clr    (in_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .acc_ovf   (acc_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: true integer sum, wrapped to ACC_W bits; overflow when they differ.
    task automatic model_step(input int a, input int b, input bit clr);
        longint sum, wrapped;
        sum = (clr ? 64'sd0 : model_acc) + longint'(a) * longint'(b);
        wrapped = sum & ((64'sd1 <<< ACC_W) - 1);
        if (wrapped >= (64'sd1 <<< (ACC_W - 1))) wrapped -= (64'sd1 <<< ACC_W);
        if (wrapped != sum) model_ovf = 1'b1;
        model_acc = wrapped;
    endtask

    function automatic logic [ACC_W-1:0] exp_acc();
        return ACC_W'(model_acc);
    endfunction

    // Launch a pair; returns cycles (negedge samples) until out_valid, 99 on timeout.
    task automatic launch(input int a, input int b, input bit clr, output int lat);
        int guard;
        @(negedge clk);
        in_a = W'(a); in_b = W'(b); in_clr = clr; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        if (lat >= 50) lat = 99;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_pair(input string name, input int a, input int b, input bit clr, input bit check_lat);
        int lat;
        launch(a, b, clr, lat);
        model_step(a, b, clr);
        tests++;
        if (out_acc !== exp_acc() || acc_ovf !== model_ovf || (check_lat && lat != 5)) begin
            fails++;
            $display("FAIL %s a=%0d b=%0d clr=%0d: got acc=%0d ovf=%0b lat=%0d, expected acc=%0d ovf=%0b lat=5",
                     name, a, b, clr, $signed(out_acc), acc_ovf, lat, $signed(exp_acc()), model_ovf);
        end else begin
            $display("[TB] %s a=%0d b=%0d clr=%0d acc=%0d ovf=%0b lat=%0d", name, a, b, clr,
                     $signed(out_acc), acc_ovf, lat);
        end
        consume();
    endtask

    task automatic test_reset();
        int lat;
        @(negedge clk);
        in_a = 8'd9; in_b = 8'd9; in_clr = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_acc !== '0 || acc_ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: got rdy=%0b vld=%0b busy=%0b acc=%0d ovf=%0b, expected 1 0 0 0 0",
                     in_ready, out_valid, busy, out_acc, acc_ovf);
        end else $display("[TB] reset_async outputs idle immediately");
        model_acc = 0; model_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk); lat++;
            tests++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_abort cycle %0d: got vld=%0b busy=%0b, expected 0 0", lat, out_valid, busy);
            end
        end
        $display("[TB] reset_abort no output after reset");
    endtask

    task automatic test_corner();
        int vals[6] = '{-128, -127, -1, 0, 1, 127};
        run_pair("corner_min_sq", -128, -128, 1'b1, 1'b1);
        tests++;
        if ($signed(out_acc) != 16384) begin
            fails++;
            $display("FAIL corner_const: got %0d, expected 16384", $signed(out_acc));
        end
        foreach (vals[i]) foreach (vals[j]) run_pair("corner", vals[i], vals[j], 1'b1, 1'b0);
    endtask

    task automatic test_accumulate();
        run_pair("accum_first", 3, 5, 1'b1, 1'b0);
        tests++;
        if ($signed(out_acc) != 15) begin
            fails++; $display("FAIL accum_first_const: got %0d, expected 15", $signed(out_acc));
        end
        run_pair("accum_second", 7, -2, 1'b0, 1'b0);
        tests++;
        if ($signed(out_acc) != 1) begin
            fails++; $display("FAIL accum_second_const: got %0d, expected 1", $signed(out_acc));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int a, b;
            bit clr;
            a = $signed(8'($urandom));
            b = $signed(8'($urandom));
            clr = ($urandom_range(0, 3) == 0);
            run_pair("random", a, b, clr, 1'b1);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [ACC_W-1:0] held;
        launch(-9, 11, 1'b1, lat);
        model_step(-9, 11, 1'b1);
        held = exp_acc();
        in_a = 8'd4; in_b = 8'd6; in_clr = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_acc !== held) begin
                fails++;
                $display("FAIL backpressure cycle %0d: got vld=%0b rdy=%0b acc=%0d, expected 1 0 %0d",
                         c, out_valid, in_ready, $signed(out_acc), $signed(held));
            end else $display("[TB] backpressure cycle %0d held acc=%0d", c, $signed(out_acc));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_idle: got rdy=%0b busy=%0b, expected 1 0", in_ready, busy);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        model_step(4, 6, 1'b0);
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        tests++;
        if (out_acc !== exp_acc() || lat != 5) begin
            fails++;
            $display("FAIL backpressure_next: got acc=%0d lat=%0d, expected acc=%0d lat=5",
                     $signed(out_acc), lat, $signed(exp_acc()));
        end else $display("[TB] backpressure_next acc=%0d", $signed(out_acc));
        consume();
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 32; k++) run_pair("ovf_chain", -128, -128, (k == 0), 1'b0);
        tests++;
        if ($signed(out_acc) != -524288 || acc_ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_wrap: got acc=%0d ovf=%0b, expected -524288 1", $signed(out_acc), acc_ovf);
        end
        run_pair("ovf_sticky", 1, 1, 1'b1, 1'b0);
        tests++;
        if ($signed(out_acc) != 1 || acc_ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky_const: got acc=%0d ovf=%0b, expected 1 1", $signed(out_acc), acc_ovf);
        end
    endtask

    task automatic test_reset_mid_iter();
        int seen;
        @(negedge clk);
        in_a = 8'd50; in_b = 8'd77; in_clr = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_acc = 0; model_ovf = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        tests++;
        if (seen != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_iter: got %0d valid cycles busy=%0b, expected 0 0", seen, busy);
        end else $display("[TB] reset_mid_iter aborted cleanly");
        run_pair("after_reset", 2, 3, 1'b0, 1'b1);
        tests++;
        if ($signed(out_acc) != 6) begin
            fails++; $display("FAIL after_reset_const: got %0d, expected 6", $signed(out_acc));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_acc !== '0 || acc_ovf !== 1'b0) begin
            fails++;
            $display("FAIL power_on_reset: got rdy=%0b vld=%0b busy=%0b acc=%0d ovf=%0b, expected 1 0 0 0 0",
                     in_ready, out_valid, busy, out_acc, acc_ovf);
        end
        test_reset();
        test_corner();
        test_accumulate();
        test_backpressure();
        test_random();
        test_overflow();
        test_reset_mid_iter();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
